uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
- Boot-time writer for the core's instruction memory.
- Receives a length-prefixed program image over the board UART RX line and writes it word by word into the instruction-memory write port.
- Verifies an XOR checksum, then releases the core from reset.
- Sits between the UART pin, instr_mem (write side) and the core reset input.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud).
- MAX_WORDS, 16384, largest accepted program length in 32-bit words.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- uart_rx  in  1  asynchronous serial input, idle high, 8N1, LSB first
- imem_we  out  1  one-cycle write strobe to instruction memory
- imem_addr  out  32  byte address of write, always word aligned
- imem_wdata  out  32  word to write
- core_rst  out  1  reset for the core; high until a verified load completes
- done  out  1  level, load verified
- err  out  1  level, framing, length or checksum error
- words_loaded  out  32  count of words written so far

Behaviour:
- Reset: rst synchronous, active-high; clock clk.
  - Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0, words_loaded=0.
  - FSM enters S_LEN; the RX sub-block enters IDLE.
  - rst mid-load discards all progress; the next image restarts from byte 0.
- RX input conditioning: uart_rx passes through a 2-FF synchronizer. Reset value of the synchronizer is 1.
- RX bit timing:
  - IDLE: a falling edge starts reception.
  - The start bit is sampled at CLKS_PER_BIT/2. If it is high, reception aborts to IDLE (glitch rejection).
  - Eight data bits are then sampled every CLKS_PER_BIT, LSB first, followed by the stop bit.
- RX result:
  - Stop bit high: rx_valid pulses 1 cycle with rx_data.
  - Stop bit low: rx_ferr pulses 1 cycle and no byte is delivered.
  - RX returns to IDLE after the stop-bit sample, so back-to-back frames are accepted.
- Byte order: all multi-byte fields are little-endian. A 2-bit byte index selects the lane: lane0 = bits [7:0] … lane3 = bits [31:24].
- FSM states:
  - S_LEN: collects 4 bytes into len.
    - len=0 → S_SUM.
    - len>MAX_WORDS → S_ERR.
    - otherwise → S_DATA.
  - S_DATA: collects 4 bytes into the word register.
    - The cycle after the 4th byte: imem_we=1 for exactly 1 cycle, with imem_wdata=word and imem_addr=4*words_loaded.
    - words_loaded increments in that same cycle.
    - When words_loaded reaches len → S_SUM.
  - S_SUM: the next byte is compared with the running XOR of all payload bytes (length bytes excluded).
    - Equal → S_DONE.
    - Not equal → S_ERR.
  - S_DONE: done=1, core_rst=0. Further RX bytes and framing errors are ignored.
  - S_ERR: err=1, core_rst stays 1, imem_we is never asserted. Only rst leaves this state.
- Any rx_ferr in S_LEN, S_DATA or S_SUM → S_ERR.
- Write addresses wrap only through the 32-bit adder. MAX_WORDS bounds them in practice.
- Latency: imem_we rises 1 cycle after rx_valid of the last byte of each word. done rises 1 cycle after rx_valid of the checksum byte.
- The checksum register resets to 0 at rst and accumulates only on bytes accepted in S_DATA.

Decomposition:
- Shared package (loader_pkg) holds:
  - FSM state encoding: S_LEN, S_DATA, S_SUM, S_DONE, S_ERR.
  - Default CLKS_PER_BIT.
  - Byte-lane index width.
- One sub-module: uart_rx_byte.
  - Contains the synchronizer, bit-timing counter and shift register.
  - Outputs rx_valid, rx_data[7:0] and rx_ferr.
  - Instantiated once.

Test Plan:
- Two-word image: bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | 90.
  - Writes: (0x0, 0x00000013), then (0x4, 0x00100093), each as a single 1-cycle imem_we.
  - Afterwards: done=1, core_rst=0, words_loaded=2.
- Same image but checksum byte 0x91 → both writes occur, then err=1, done=0, core_rst stays 1.
- Zero-length image: bytes 00 00 00 00 | 00 → no imem_we, done=1, core_rst=0.
- Length 0x00004001 (MAX_WORDS+1) → err=1 immediately after the 4th length byte; no writes.
- Stop bit driven low on the 2nd data byte → err=1, and no write for that word.
- Half-bit low glitch on uart_rx while idle → no byte delivered. A valid image sent afterwards loads normally.
- rst asserted after the 6th byte of the two-word image, then the full image resent → identical result to the two-word case, with the first write at address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared state encodings and constants for the UART imem loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int c_DEF_CLKS_PER_BIT = 868;
    localparam int c_LANE_W           = 2;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_SUM  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART receiver with 2-FF synchronizer and mid-bit sampling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_ferr
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t          r_state;
    logic [1:0]         r_sync;
    logic               r_prev;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_valid;
    logic [7:0]         r_data;
    logic               r_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_prev  <= r_sync[1];
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (r_prev && !r_sync[1]) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync[1], r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync[1]) begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_rx_valid = r_valid;
    assign o_rx_data  = r_data;
    assign o_rx_ferr  = r_ferr;

endmodule

`default_nettype wire

// File: rtl/uart_imem_loader.sv
// ============================================================================
// Module   : uart_imem_loader
// Brief    : Loads a length-prefixed, XOR-checked image from UART into imem.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT,
    parameter int MAX_WORDS    = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err,
    output logic [31:0] words_loaded
);

    localparam logic [31:0] c_MAX_WORDS = 32'(MAX_WORDS);

    logic       w_rx_valid;
    logic [7:0] w_rx_data;
    logic       w_rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (uart_rx),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .o_rx_ferr  (w_rx_ferr)
    );

    ld_state_t           r_state;
    logic [c_LANE_W-1:0] r_lane;
    logic [31:0]         r_len;
    logic [31:0]         r_word;
    logic [7:0]          r_sum;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_core_rst;
    logic                r_done;
    logic                r_err;
    logic [31:0]         r_words;

    // Fully assembled fields including the byte arriving this cycle (lane 3).
    logic [31:0] w_len_full;
    logic [31:0] w_word_full;
    logic [31:0] w_words_next;

    assign w_len_full   = {w_rx_data, r_len[23:0]};
    assign w_word_full  = {w_rx_data, r_word[23:0]};
    assign w_words_next = r_words + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LEN;
            r_lane     <= '0;
            r_len      <= '0;
            r_word     <= '0;
            r_sum      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_rx_ferr) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else if (w_rx_valid) begin
                        r_len[r_lane*8 +: 8] <= w_rx_data;
                        r_lane               <= r_lane + 1'b1;
                        if (r_lane == 2'd3) begin
                            if (w_len_full == 32'd0) begin
                                r_state <= S_SUM;
                            end else if (w_len_full > c_MAX_WORDS) begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_ferr) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else if (w_rx_valid) begin
                        r_word[r_lane*8 +: 8] <= w_rx_data;
                        r_sum                 <= r_sum ^ w_rx_data;
                        r_lane                <= r_lane + 1'b1;
                        if (r_lane == 2'd3) begin
                            r_we    <= 1'b1;
                            r_wdata <= w_word_full;
                            r_addr  <= {r_words[29:0], 2'b00};
                            r_words <= w_words_next;
                            if (w_words_next == r_len) begin
                                r_state <= S_SUM;
                            end
                        end
                    end
                end
                S_SUM: begin
                    if (w_rx_ferr) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else if (w_rx_valid) begin
                        if (w_rx_data == r_sum) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done     <= 1'b1;
                    r_core_rst <= 1'b0;
                end
                S_ERR: begin
                    r_err      <= 1'b1;
                    r_core_rst <= 1'b1;
                end
                default: begin
                    r_state <= S_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_rst     = r_core_rst;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule

`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
// ============================================================================
// Module   : tb_uart_imem_loader
// Brief    : Directed scoreboard bench for the UART instruction-memory loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_imem_loader;

    localparam int c_CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;
    logic [31:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic        mon_prev_we = 1'b0;
    int          mon_dbl = 0;

    uart_imem_loader #(
        .CLKS_PER_BIT (c_CPB),
        .MAX_WORDS    (16384)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every write strobe; flag strobes wider than one cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            obs_q.push_back({imem_addr, imem_wdata});
            if (mon_prev_we) mon_dbl++;
        end
        mon_prev_we <= imem_we;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        uart_rx = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (c_CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (c_CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Drain scoreboard: every expected write must match, none may be extra.
    task automatic check_writes(input string tag);
        logic [63:0] e;
        logic [63:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            else o = 64'hDEAD_DEAD_DEAD_DEAD;
            chk({tag, "_write"}, o, e);
        end
        chk({tag, "_extra_writes"}, 64'(obs_q.size()), 64'd0);
        obs_q.delete();
    endtask

    task automatic send_two_word(input logic [7:0] sum);
        logic [7:0] img [13];
        img = '{8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        img[12] = sum;
        expect_write(32'h0, 32'h0000_0013);
        expect_write(32'h4, 32'h0010_0093);
        for (int i = 0; i < 13; i++) send_byte(img[i]);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_we",    64'(imem_we),      64'd0);
        chk("reset_addr",  64'(imem_addr),    64'd0);
        chk("reset_wdata", 64'(imem_wdata),   64'd0);
        chk("reset_core",  64'(core_rst),     64'd1);
        chk("reset_done",  64'(done),         64'd0);
        chk("reset_err",   64'(err),          64'd0);
        chk("reset_words", 64'(words_loaded), 64'd0);
        do_reset();

        // Good two-word image.
        send_two_word(8'h90);
        check_writes("two_word");
        chk("two_word_done",  64'(done),         64'd1);
        chk("two_word_core",  64'(core_rst),     64'd0);
        chk("two_word_err",   64'(err),          64'd0);
        chk("two_word_words", 64'(words_loaded), 64'd2);
        // Bytes after completion are ignored.
        send_byte(8'h55);
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        chk("done_sticky", 64'({done, err, core_rst}), 64'b100);
        check_writes("after_done");
        do_reset();

        // Bad checksum.
        send_two_word(8'h91);
        check_writes("bad_sum");
        chk("bad_sum_flags", 64'({done, err, core_rst}), 64'b011);
        do_reset();

        // Zero-length image.
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00);
        repeat (4) @(negedge clk);
        check_writes("zero_len");
        chk("zero_len_flags", 64'({done, err, core_rst}), 64'b100);
        chk("zero_len_words", 64'(words_loaded), 64'd0);
        do_reset();

        // Length one above MAX_WORDS.
        send_byte(8'h01); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
        chk("too_long_err", 64'({done, err, core_rst}), 64'b011);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (4) @(negedge clk);
        check_writes("too_long");
        chk("too_long_words", 64'(words_loaded), 64'd0);
        do_reset();

        // Framing error on the second data byte.
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h13);
        repeat (4) @(negedge clk);
        check_writes("ferr");
        chk("ferr_flags", 64'({done, err, core_rst}), 64'b011);
        chk("ferr_words", 64'(words_loaded), 64'd0);
        do_reset();

        // Half-bit glitch while idle, then a normal image.
        uart_rx = 1'b0;
        repeat (c_CPB / 2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * c_CPB) @(negedge clk);
        chk("glitch_state", 64'({done, err, core_rst}), 64'b001);
        send_two_word(8'h90);
        check_writes("glitch");
        chk("glitch_flags", 64'({done, err, core_rst}), 64'b100);
        chk("glitch_words", 64'(words_loaded), 64'd2);
        do_reset();

        // Reset mid-load, then full resend.
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        do_reset();
        chk("midrst_words", 64'(words_loaded), 64'd0);
        send_two_word(8'h90);
        check_writes("midrst");
        chk("midrst_flags", 64'({done, err, core_rst}), 64'b100);
        chk("midrst_words_end", 64'(words_loaded), 64'd2);

        chk("single_cycle_we", 64'(mon_dbl), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
